// File: rtl/barrel_shift_pipe.sv
// -----------------------------------------------------------------------------
// barrel_shift_pipe
//
// Pipelined barrel shifter/rotator with valid/ready handshakes on both sides.
// The shift amount is consumed one bit per stage. Stage k shifts or rotates by
// 2^k when its shift-amount bit is set. Otherwise it passes the data through.
//
// Handshake rule (both ports): a transfer happens on a rising clock edge when
// valid and ready are both high in that cycle. A producer holding valid high
// keeps its payload stable until the transfer. The whole pipeline advances as
// one unit whenever the output register is empty or is being drained this
// cycle. The input is ready exactly then.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   request present on a/b/op
//   in_ready   block accepts the request this cycle (combinational advance)
//   a          operand, WIDTH bits
//   b          unsigned shift amount, SW bits
//   op         000 SRA, 010 SRL, 001/011 SLL, 100 ROR, 101 ROL, 11x pass
//   out_valid  result present on c/zero
//   out_ready  consumer accepts the result this cycle
//   c          result, registered
//   zero       high when c is all zeros (decoded from the last stage register)
// -----------------------------------------------------------------------------
module barrel_shift_pipe #(
  parameter int WIDTH = 32,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [SW-1:0]    b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             zero
);

  // Per-stage state: data, op, the shift-amount bits not yet consumed, valid.
  logic [WIDTH-1:0] data_q [SW];
  logic [WIDTH-1:0] data_d [SW];
  logic [2:0]       op_q   [SW];
  logic [2:0]       op_d   [SW];
  logic [SW-1:0]    b_q    [SW];
  logic [SW-1:0]    b_d    [SW];
  logic [SW-1:0]    valid_q;
  logic [SW-1:0]    valid_d;
  logic             advance;

  // One stage of the barrel: shift/rotate by 2^k when en is set.
  // Arithmetic right shifts compose across stages because each stage keeps the
  // sign bit in place, so the fill always equals the original MSB.
  function automatic logic [WIDTH-1:0] stage_fn(input logic [WIDTH-1:0] d,
                                                input logic [2:0]       o,
                                                input logic             en,
                                                input int               k);
    int unsigned      amt;
    logic [WIDTH-1:0] r;
    amt = 32'd1 << k;
    r   = d;
    if (en) begin
      case (o)
        3'b000:         r = $signed(d) >>> amt;
        3'b010:         r = d >> amt;
        3'b001, 3'b011: r = d << amt;
        3'b100:         r = (d >> amt) | (d << (WIDTH - amt));
        3'b101:         r = (d << amt) | (d >> (WIDTH - amt));
        default:        r = d;
      endcase
    end
    return r;
  endfunction

  // Global stall: everything freezes only when a result sits unaccepted.
  assign advance  = out_ready | ~valid_q[SW-1];
  assign in_ready = advance;

  always_comb begin
    data_d[0]  = stage_fn(a, op, b[0], 0);
    op_d[0]    = op;
    b_d[0]     = b >> 1;
    valid_d[0] = in_valid & advance;
    for (int k = 1; k < SW; k++) begin
      data_d[k]  = stage_fn(data_q[k-1], op_q[k-1], b_q[k-1][0], k);
      op_d[k]    = op_q[k-1];
      b_d[k]     = b_q[k-1] >> 1;
      valid_d[k] = valid_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < SW; k++) begin
        data_q[k] <= '0;
        op_q[k]   <= '0;
        b_q[k]    <= '0;
      end
    end else if (advance) begin
      valid_q <= valid_d;
      for (int k = 0; k < SW; k++) begin
        data_q[k] <= data_d[k];
        op_q[k]   <= op_d[k];
        b_q[k]    <= b_d[k];
      end
    end
  end

  assign out_valid = valid_q[SW-1];
  assign c         = data_q[SW-1];
  assign zero      = ~|data_q[SW-1];

endmodule
